anti_theft_timer_ctrl: RTL and testbench

//  Owns the anti-theft system's single interval timer and its programmable delay table.

---
 rtl/anti_theft_pkg.sv | 22 ++
 rtl/one_hz_prescaler.sv | 32 +++
 rtl/anti_theft_timer_ctrl.sv | 92 +++++++++
 tb/tb_anti_theft_timer_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/anti_theft_pkg.sv
// Shared types and reset defaults for the anti-theft interval timer.
package anti_theft_pkg;

  typedef enum logic [1:0] {
    INT_ARM,
    INT_DRIVER,
    INT_PASSENGER,
    INT_ALARM
  } interval_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRE
  } tmr_state_e;

  localparam int DEF_T_ARM       = 6;
  localparam int DEF_T_DRIVER    = 8;
  localparam int DEF_T_PASSENGER = 15;
  localparam int DEF_T_ALARM     = 10;

endpackage

// File: rtl/one_hz_prescaler.sv
// Free-running seconds prescaler; tick is registered and follows count==CLK_FREQ_HZ-1 by one cycle.
module one_hz_prescaler #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (hold) begin
      tick  <= 1'b0;
    end else begin
      tick  <= (count == LAST);
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/anti_theft_timer_ctrl.sv
// Interval timer with a reprogrammable 4-entry delay table for the anti-theft FSM.
// Optional `TIMER_HOLD_EN adds a timer_hold input that freezes the countdown.
module anti_theft_timer_ctrl
  import anti_theft_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TW          = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [1:0]    prog_sel,
  input  logic [TW-1:0] prog_val,
  input  logic          start_timer,
  input  logic [1:0]    interval_sel,
`ifdef TIMER_HOLD_EN
  input  logic          timer_hold,
`endif
  output logic          one_hz_enable,
  output logic          timer_busy,
  output logic [TW-1:0] time_left,
  output logic          timer_expired
);

  logic          hold;
  logic          tick_ok;
  logic [TW-1:0] tbl [4];
  tmr_state_e    state;

`ifdef TIMER_HOLD_EN
  assign hold = timer_hold;
`else
  assign hold = 1'b0;
`endif

  one_hz_prescaler #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_timer),
    .hold  (hold),
    .tick  (one_hz_enable)
  );

  // A tick registered just before hold rises must not decrement a frozen countdown.
  assign tick_ok = one_hz_enable & ~hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl[INT_ARM]       <= TW'(DEF_T_ARM);
      tbl[INT_DRIVER]    <= TW'(DEF_T_DRIVER);
      tbl[INT_PASSENGER] <= TW'(DEF_T_PASSENGER);
      tbl[INT_ALARM]     <= TW'(DEF_T_ALARM);
    end else if (prog_we && (prog_val != '0)) begin
      tbl[prog_sel] <= prog_val;
    end
  end

  // Start reads the table before any same-edge write lands, so it loads the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      time_left     <= '0;
      timer_busy    <= 1'b0;
      timer_expired <= 1'b0;
    end else begin
      timer_expired <= 1'b0;
      if (start_timer) begin
        state      <= RUN;
        time_left  <= tbl[interval_sel];
        timer_busy <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (tick_ok) begin
              if (time_left > TW'(1)) begin
                time_left <= time_left - TW'(1);
              end else begin
                state         <= EXPIRE;
                time_left     <= '0;
                timer_busy    <= 1'b0;
                timer_expired <= 1'b1;
              end
            end
          end
          EXPIRE:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anti_theft_timer_ctrl.sv
// Scoreboard bench: starts push expected expiry cycles, a negedge monitor pops them on each pulse.
module tb_anti_theft_timer_ctrl;
  import anti_theft_pkg::*;

  localparam int F  = 10;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [1:0]    prog_sel = 2'd0;
  logic [TW-1:0] prog_val = '0;
  logic          start_timer = 1'b0;
  logic [1:0]    interval_sel = 2'd0;
  logic          one_hz_enable;
  logic          timer_busy;
  logic [TW-1:0] time_left;
  logic          timer_expired;
`ifdef TIMER_HOLD_EN
  logic          timer_hold = 1'b0;
`endif

  anti_theft_timer_ctrl #(.CLK_FREQ_HZ(F), .TW(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .prog_we       (prog_we),
    .prog_sel      (prog_sel),
    .prog_val      (prog_val),
    .start_timer   (start_timer),
    .interval_sel  (interval_sel),
`ifdef TIMER_HOLD_EN
    .timer_hold    (timer_hold),
`endif
    .one_hz_enable (one_hz_enable),
    .timer_busy    (timer_busy),
    .time_left     (time_left),
    .timer_expired (timer_expired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && timer_expired === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_expired: pulse at cycle %0d, none expected", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc != e) begin
          n_fail++;
          $display("FAIL expired_cycle: got cycle %0d, expected %0d", cyc, e);
        end
      end
    end
  end

  task automatic start_iv(input logic [1:0] sel, input int n, input int extra,
                          input bit pw, input logic [TW-1:0] pv, output int s);
    @(negedge clk);
    start_timer  = 1'b1;
    interval_sel = sel;
    prog_we      = pw;
    prog_sel     = sel;
    prog_val     = pv;
    exp_q.delete();
    s = cyc + 1;
    exp_q.push_back(s + n * F + 1 + extra);
    @(negedge clk);
    start_timer = 1'b0;
    prog_we     = 1'b0;
  endtask

  task automatic prog(input logic [1:0] sel, input logic [TW-1:0] val);
    @(negedge clk);
    prog_we  = 1'b1;
    prog_sel = sel;
    prog_val = val;
    @(negedge clk);
    prog_we  = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input string name, input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: no expiry within %0d cycles, %0d pending", name, limit, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    #12;
    check("rst_busy", timer_busy, 0);
    check("rst_time_left", time_left, 0);
    check("rst_expired", timer_expired, 0);
    check("rst_one_hz", one_hz_enable, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: ARM default
    start_iv(INT_ARM, 6, 0, 1'b0, '0, s);
    check("t1_busy", timer_busy, 1);
    check("t1_time_left", time_left, 6);
    wait_cyc(s + F - 1);
    check("t1_no_tick_early", one_hz_enable, 0);
    wait_cyc(s + F);
    check("t1_first_tick", one_hz_enable, 1);
    check("t1_tl_before_dec", time_left, 6);
    wait_cyc(s + F + 1);
    check("t1_tl_after_dec", time_left, 5);
    drain("t1_drain", 100);
    check("t1_busy_end", timer_busy, 0);
    check("t1_tl_end", time_left, 0);

    // 2: reprogram DRIVER, zero write ignored
    prog(INT_DRIVER, 4'd3);
    start_iv(INT_DRIVER, 3, 0, 1'b0, '0, s);
    check("t2_tl3", time_left, 3);
    wait_cyc(s + F);
    check("t2_tl3_hold", time_left, 3);
    wait_cyc(s + F + 1);
    check("t2_tl2", time_left, 2);
    wait_cyc(s + 2 * F + 1);
    check("t2_tl1", time_left, 1);
    drain("t2_drain", 50);
    check("t2_tl0", time_left, 0);
    prog(INT_DRIVER, 4'd0);
    start_iv(INT_DRIVER, 3, 0, 1'b0, '0, s);
    check("t2_zero_ignored", time_left, 3);
    drain("t2b_drain", 50);

    // 3: restart from RUN, table write during run
    start_iv(INT_PASSENGER, 15, 0, 1'b0, '0, s);
    check("t3_tl15", time_left, 15);
    wait_cyc(s + 2 * F + 1);
    check("t3_tl13", time_left, 13);
    start_iv(INT_ALARM, 10, 0, 1'b0, '0, s);
    check("t3_tl10", time_left, 10);
    prog(INT_ALARM, 4'd4);
    wait_cyc(s + F + 1);
    check("t3_tl9_unaffected", time_left, 9);
    drain("t3_drain", 120);

    // 4: same-cycle program and start loads old value
    start_iv(INT_ARM, 6, 0, 1'b1, 4'd2, s);
    check("t4_old_value", time_left, 6);
    start_iv(INT_ARM, 2, 0, 1'b0, '0, s);
    check("t4_new_value", time_left, 2);
    drain("t4_drain", 40);

    // 5: async reset mid-run
    start_iv(INT_ALARM, 4, 0, 1'b0, '0, s);
    check("t5_tl4", time_left, 4);
    wait_cyc(s + 5);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_busy", timer_busy, 0);
    check("t5_rst_tl", time_left, 0);
    check("t5_rst_expired", timer_expired, 0);
    check("t5_rst_one_hz", one_hz_enable, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    start_iv(INT_ARM, 6, 0, 1'b0, '0, s);
    check("t5_def_arm", time_left, 6);
    start_iv(INT_DRIVER, 8, 0, 1'b0, '0, s);
    check("t5_def_driver", time_left, 8);
    start_iv(INT_ALARM, 10, 0, 1'b0, '0, s);
    check("t5_def_alarm", time_left, 10);
    drain("t5_drain", 120);

`ifdef TIMER_HOLD_EN
    // 6: hold for 25 cycles mid-run
    start_iv(INT_ARM, 6, 25, 1'b0, '0, s);
    wait_cyc(s + 25);
    check("t6_tl_hold_start", time_left, 4);
    timer_hold = 1'b1;
    wait_cyc(s + 50);
    check("t6_tl_hold_end", time_left, 4);
    timer_hold = 1'b0;
    wait_cyc(s + 55);
    check("t6_tl_before_dec", time_left, 4);
    wait_cyc(s + 56);
    check("t6_tl_after_dec", time_left, 3);
    drain("t6_drain", 120);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
